// File: rtl/led_pattern_pkg.sv
// Shared mode encodings and helpers for the LED pattern engine.
// Optional breathe mode is enabled by LED_PATTERN_BREATHE_EN.
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_BIN     = 2'd0,
    MODE_GRAY    = 2'd1,
    MODE_SCAN    = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  function automatic logic [31:0] bin2gray(
    input logic [31:0] b
  );
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/led_pattern_if.sv
// Control/status bundle between a pattern client and the LED engine.
// The engine (slave) drives leds/tick; the client drives en/mode.
interface led_pattern_if #(
  parameter int N_LEDS = 5
);
  import led_pattern_pkg::*;

  logic              en;
  logic [1:0]        mode;
  logic [N_LEDS-1:0] leds;
  logic              tick;

  modport master (
    output en,
    output mode,
    input  leds,
    input  tick
  );

  modport slave (
    input  en,
    input  mode,
    output leds,
    output tick
  );

endinterface

// File: rtl/led_prescaler.sv
// Free-running prescaler producing the pattern step and breathe events.
// Both events are qualified by en so a frozen counter never fires.
module led_prescaler #(
  parameter int LOG2DELAY     = 22,
  parameter int BREATHE_SHIFT = 14
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic step_evt,
  output logic b_evt
);

  logic [LOG2DELAY-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + LOG2DELAY'(1);
    end
  end

  assign step_evt = en & (&cnt_q);
  assign b_evt    = en & (&cnt_q[BREATHE_SHIFT-1:0]);

endmodule

// File: rtl/led_pattern_gen.sv
// N-channel LED pattern engine: binary, Gray, bouncing scan, breathe.
// Breathe (mode 3) exists only with LED_PATTERN_BREATHE_EN, else Gray.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int N_LEDS        = 5,
  parameter int LOG2DELAY     = 22,
  parameter int PWM_BITS      = 8,
  parameter int BREATHE_SHIFT = 14
) (
  input  logic          clk,
  input  logic          rst,
  led_pattern_if.slave  bus
);

  localparam int PW = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;

  logic step_evt;
  logic b_evt;

  led_prescaler #(
    .LOG2DELAY     (LOG2DELAY),
    .BREATHE_SHIFT (BREATHE_SHIFT)
  ) u_presc (
    .clk      (clk),
    .rst      (rst),
    .en       (bus.en),
    .step_evt (step_evt),
    .b_evt    (b_evt)
  );

  mode_e             mode_q;
  logic [N_LEDS-1:0] step_q;
  logic [N_LEDS-1:0] step_n;
  logic [PW-1:0]     pos_q;
  logic [PW-1:0]     pos_n;
  logic              up_q;
  logic              up_n;
  logic [N_LEDS-1:0] pat_n;
  logic [N_LEDS-1:0] leds_q;
  logic              tick_q;
  logic              pwm_on;

`ifdef LED_PATTERN_BREATHE_EN
  logic [PWM_BITS-1:0] duty_q;
  logic [PWM_BITS-1:0] pwm_q;
  logic                dup_q;

  assign pwm_on = pwm_q < duty_q;

  // Duty bounces 0..max..0; each extreme is held for one b_evt.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_q <= '0;
      pwm_q  <= '0;
      dup_q  <= 1'b1;
    end else if (bus.en) begin
      pwm_q <= pwm_q + PWM_BITS'(1);
      if (b_evt) begin
        if (dup_q) begin
          if (&duty_q) begin
            dup_q  <= 1'b0;
            duty_q <= duty_q - PWM_BITS'(1);
          end else begin
            duty_q <= duty_q + PWM_BITS'(1);
          end
        end else begin
          if (duty_q == '0) begin
            dup_q  <= 1'b1;
            duty_q <= duty_q + PWM_BITS'(1);
          end else begin
            duty_q <= duty_q - PWM_BITS'(1);
          end
        end
      end
    end
  end
`else
  assign pwm_on = 1'b0;
`endif

  always_comb begin
    step_n = step_q + N_LEDS'(1);
    pos_n  = pos_q;
    up_n   = up_q;
    if (N_LEDS > 1) begin
      if (up_q) begin
        if (pos_q == PW'(N_LEDS - 1)) begin
          up_n  = 1'b0;
          pos_n = pos_q - PW'(1);
        end else begin
          pos_n = pos_q + PW'(1);
        end
      end else begin
        if (pos_q == '0) begin
          up_n  = 1'b1;
          pos_n = pos_q + PW'(1);
        end else begin
          pos_n = pos_q - PW'(1);
        end
      end
    end
  end

  // Pattern for the step being entered, decoded from the new mode.
  always_comb begin
    pat_n = step_n;
    unique case (1'b1)
      (bus.mode == MODE_BIN):
        pat_n = step_n;
      (bus.mode == MODE_GRAY):
        pat_n = N_LEDS'(bin2gray(32'(step_n)));
      (bus.mode == MODE_SCAN):
        pat_n = N_LEDS'(1) << pos_n;
`ifdef LED_PATTERN_BREATHE_EN
      (bus.mode == MODE_BREATHE):
        pat_n = {N_LEDS{pwm_on}};
`else
      (bus.mode == MODE_BREATHE):
        pat_n = N_LEDS'(bin2gray(32'(step_n)));
`endif
      default:
        pat_n = step_n;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= MODE_BIN;
      step_q <= '0;
      pos_q  <= '0;
      up_q   <= 1'b1;
      leds_q <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (step_evt) begin
        mode_q <= mode_e'(bus.mode);
        step_q <= step_n;
        pos_q  <= pos_n;
        up_q   <= up_n;
        leds_q <= pat_n;
        tick_q <= 1'b1;
      end else if (bus.en && mode_q == MODE_BREATHE) begin
`ifdef LED_PATTERN_BREATHE_EN
        leds_q <= {N_LEDS{pwm_on}};
`else
        leds_q <= leds_q;
`endif
      end
    end
  end

  assign bus.leds = leds_q;
  assign bus.tick = tick_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen (N=4 and N=1 instances).
// Breathe expectations follow LED_PATTERN_BREATHE_EN when defined.
module tb_led_pattern_gen;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] mode;

  int n_chk;
  int n_err;

`ifdef LED_PATTERN_BREATHE_EN
  localparam bit BR = 1'b1;
`else
  localparam bit BR = 1'b0;
`endif

  led_pattern_if #(.N_LEDS(4)) ifc4 ();
  led_pattern_if #(.N_LEDS(1)) ifc1 ();

  assign ifc4.en   = en;
  assign ifc4.mode = mode;
  assign ifc1.en   = en;
  assign ifc1.mode = mode;

  led_pattern_gen #(
    .N_LEDS(4), .LOG2DELAY(2), .PWM_BITS(3), .BREATHE_SHIFT(1)
  ) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (ifc4.slave)
  );

  led_pattern_gen #(
    .N_LEDS(1), .LOG2DELAY(2), .PWM_BITS(3), .BREATHE_SHIFT(1)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (ifc1.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Duty after k breathe events: triangle 0..7..0 with period 14.
  function automatic int duty_at(int k);
    int r;
    r = k % 14;
    return (r <= 7) ? r : 14 - r;
  endfunction

  // Pattern of step s (count since reset) on an n-LED engine; e is the
  // enabled-cycle count at the event, used for the PWM compare.
  function automatic int patt(int m, int s, int n, int e);
    int st, p, r, pos;
    st = s % (1 << n);
    if (m == 3) begin
      if (BR) return (duty_at(e / 2) > (e % 8)) ? (1 << n) - 1 : 0;
      m = 1;
    end
    if (m == 0) return st;
    if (m == 1) return st ^ (st >> 1);
    if (n == 1) return 1;
    p   = 2 * (n - 1);
    r   = s % p;
    pos = (r < n) ? r : p - r;
    return 1 << pos;
  endfunction

  // Model: every output follows from the count of enabled cycles.
  int  enc;
  int  mq;
  int  e4;
  int  e1;
  bit  et;
  bit  started;

  always @(posedge clk) begin
    started = 1'b1;
    if (rst) begin
      enc = 0;
      mq  = 0;
      e4  = 0;
      e1  = 0;
      et  = 1'b0;
    end else if (en) begin
      et = 1'b0;
      if (enc % 4 == 3) begin
        mq = int'(mode);
        e4 = patt(mq, enc / 4 + 1, 4, enc);
        e1 = patt(mq, enc / 4 + 1, 1, enc);
        et = 1'b1;
      end else if (BR && mq == 3) begin
        e4 = patt(3, 0, 4, enc);
        e1 = patt(3, 0, 1, enc);
      end
      enc++;
    end else begin
      et = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("leds4", 32'(ifc4.leds), 32'(e4));
      chk("tick4", 32'(ifc4.tick), 32'(et));
      chk("leds1", 32'(ifc1.leds), 32'(e1));
      chk("tick1", 32'(ifc1.tick), 32'(et));
    end
  end

  task automatic do_reset(input logic [1:0] m);
    rst  = 1'b1;
    en   = 1'b1;
    mode = m;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  int scan_exp [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100,
                       4'b0010, 4'b0001, 4'b0010};

  initial begin
    n_chk = 0;
    n_err = 0;
    rst  = 1'b1;
    en   = 1'b1;
    mode = 2'd0;
    repeat (2) @(negedge clk);
    chk("rst_leds", 32'(ifc4.leds), 32'h0);
    chk("rst_tick", 32'(ifc4.tick), 32'h0);
    rst = 1'b0;

    repeat (4) @(negedge clk);
    chk("bin_first", 32'(ifc4.leds), 32'b0001);
    chk("bin_first_tick", 32'(ifc4.tick), 32'h1);
    repeat (56) @(negedge clk);
    chk("bin_15", 32'(ifc4.leds), 32'b1111);
    repeat (4) @(negedge clk);
    chk("bin_wrap", 32'(ifc4.leds), 32'b0000);
    chk("bin_wrap_tick", 32'(ifc4.tick), 32'h1);

    do_reset(2'd1);
    repeat (4) @(negedge clk);
    chk("gray_1", 32'(ifc4.leds), 32'b0001);
    repeat (4) @(negedge clk);
    chk("gray_2", 32'(ifc4.leds), 32'b0011);
    repeat (4) @(negedge clk);
    chk("gray_3", 32'(ifc4.leds), 32'b0010);
    repeat (4) @(negedge clk);
    chk("gray_4", 32'(ifc4.leds), 32'b0110);
    repeat (44) @(negedge clk);
    chk("gray_15", 32'(ifc4.leds), 32'b1000);

    do_reset(2'd2);
    for (int i = 0; i < 7; i++) begin
      repeat (4) @(negedge clk);
      chk("scan4", 32'(ifc4.leds), 32'(scan_exp[i]));
      chk("scan1", 32'(ifc1.leds), 32'h1);
    end

    do_reset(2'd0);
    repeat (12) @(negedge clk);
    chk("sw_pre", 32'(ifc4.leds), 32'b0011);
    repeat (2) @(negedge clk);
    mode = 2'd2;
    @(negedge clk);
    chk("sw_hold", 32'(ifc4.leds), 32'b0011);
    chk("sw_hold_tick", 32'(ifc4.tick), 32'h0);
    @(negedge clk);
    chk("sw_scan", 32'(ifc4.leds), 32'b0100);
    chk("sw_scan_tick", 32'(ifc4.tick), 32'h1);

    repeat (3) @(negedge clk);
    en = 1'b0;
    repeat (10) @(negedge clk);
    chk("en_hold", 32'(ifc4.leds), 32'b0100);
    chk("en_hold_tick", 32'(ifc4.tick), 32'h0);
    en = 1'b1;
    @(negedge clk);
    chk("en_resume", 32'(ifc4.leds), 32'b0010);
    chk("en_resume_tick", 32'(ifc4.tick), 32'h1);

    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstp_leds", 32'(ifc4.leds), 32'h0);
    chk("rstp_tick", 32'(ifc4.tick), 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("rstp_restart", 32'(ifc4.leds), 32'b0010);

    do_reset(2'd3);
    repeat (9) @(negedge clk);
    chk("br_e8", 32'(ifc4.leds), BR ? 32'b1111 : 32'b0011);
    repeat (40) @(negedge clk);
    en = 1'b0;
    repeat (5) @(negedge clk);
    en = 1'b1;
    repeat (60) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
